// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the execute stage and the M-extension sequencer.
// The execute stage owns the master modport; the sequencer owns the slave modport.
interface muldiv_seq_if #(
   parameter int XLEN = 32
);
   // Both channels transfer on a rising edge where valid && ready are high. A valid
   // may not depend on the ready of its own channel. Once raised, resp_valid and
   // result hold until the transfer completes or a flush clears the sequencer.
   logic            req_valid;
   logic            req_ready;
   logic [3:0]      op;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic            resp_valid;
   logic            resp_ready;
   logic [XLEN-1:0] result;

   modport master (
      output req_valid, op, rs1, rs2, resp_ready,
      input  req_ready, resp_valid, result
   );

   modport slave (
      input  req_valid, op, rs1, rs2, resp_ready,
      output req_ready, resp_valid, result
   );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative radix-2 multiply/divide sequencer for the execute stage.
// One operation in flight; shift-add multiply and restoring divide take XLEN cycles.
module muldiv_seq #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   muldiv_seq_if.slave  bus,
   output logic         busy,
   output logic [1:0]   dbg_state_o
);
   // ALU control codes for the M extension; all other codes are non-M operations.
   localparam logic [3:0] OP_MUL    = 4'h8;
   localparam logic [3:0] OP_MULH   = 4'h9;
   localparam logic [3:0] OP_MULHSU = 4'hA;
   localparam logic [3:0] OP_MULHU  = 4'hB;
   localparam logic [3:0] OP_DIV    = 4'hC;
   localparam logic [3:0] OP_DIVU   = 4'hD;
   localparam logic [3:0] OP_REM    = 4'hE;
   localparam logic [3:0] OP_REMU   = 4'hF;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [3:0]          op_q, op_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     opb_q, opb_d;
   logic                neg_q, neg_d;
   logic                rneg_q, rneg_d;
   logic                fast_q, fast_d;
   logic [XLEN-1:0]     fres_q, fres_d;

   logic                accept, is_m, is_mul, signed_a, signed_b, sa, sb;
   logic                div_zero, ovf, fast;
   logic [XLEN-1:0]     mag_a, mag_b, fast_res;
   logic [XLEN:0]       mul_sum, rem_sh, rem_diff;
   logic                rem_ge;
   logic [2*XLEN-1:0]   prod_c;
   logic [XLEN-1:0]     quot_c, rem_c, res_sel;

   assign accept = (state_q == IDLE) && bus.req_valid && !flush;

   // Decode of the operation presented on the request channel.
   always_comb begin
      is_m     = bus.op[3];
      is_mul   = (bus.op[3:2] == 2'b10);
      signed_a = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                 (bus.op == OP_DIV)  || (bus.op == OP_REM);
      signed_b = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
      sa       = signed_a && bus.rs1[XLEN-1];
      sb       = signed_b && bus.rs2[XLEN-1];
      mag_a    = sa ? -bus.rs1 : bus.rs1;
      mag_b    = sb ? -bus.rs2 : bus.rs2;
      div_zero = (bus.op[3:2] == 2'b11) && (bus.rs2 == '0);
      ovf      = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                 (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);
      fast     = !is_m || div_zero || ovf;
      fast_res = '0;
      if (div_zero) begin
         fast_res = ((bus.op == OP_DIV) || (bus.op == OP_DIVU)) ? '1 : bus.rs1;
      end else if (ovf) begin
         fast_res = (bus.op == OP_DIV) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
      end
   end

   // One radix-2 step. The divide partial remainder needs XLEN+1 bits after the shift.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      rem_sh   = acc_q[2*XLEN-1:XLEN-1];
      rem_diff = rem_sh - {1'b0, opb_q};
      rem_ge   = (rem_sh >= {1'b0, opb_q});
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      acc_d   = acc_q;
      opb_d   = opb_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      fast_d  = fast_q;
      fres_d  = fres_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d   = bus.op;
               neg_d  = sa ^ sb;
               rneg_d = sa;
               fast_d = fast;
               fres_d = fast_res;
               opb_d  = is_mul ? mag_a : mag_b;
               acc_d  = {{XLEN{1'b0}}, (is_mul ? mag_b : mag_a)};
               if (fast) begin
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  cnt_d   = CNT_W'(XLEN);
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (op_q[2] == 1'b0) begin
               acc_d = {mul_sum, acc_q[XLEN-1:1]};
            end else begin
               acc_d = {(rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0]),
                        acc_q[XLEN-2:0], rem_ge};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         acc_q   <= '0;
         opb_q   <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         fast_q  <= 1'b0;
         fres_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         opb_q   <= opb_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         fast_q  <= fast_d;
         fres_q  <= fres_d;
      end
   end

   // Sign correction is applied to the full product so MULH* get the right high half.
   always_comb begin
      prod_c = neg_q ? -acc_q : acc_q;
      quot_c = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem_c  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      case (op_q)
         OP_MUL:                        res_sel = prod_c[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  res_sel = prod_c[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:               res_sel = quot_c;
         OP_REM, OP_REMU:               res_sel = rem_c;
         default:                       res_sel = '0;
      endcase
      if (fast_q) begin
         res_sel = fres_q;
      end
   end

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = (state_q == DONE);
   assign bus.result     = (state_q == DONE) ? res_sel : '0;
   assign busy           = (state_q != IDLE);
   assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, results, fast paths, flush, reset, backpressure.
module tb_muldiv_seq;
   localparam logic [3:0] OP_MUL    = 4'h8;
   localparam logic [3:0] OP_MULH   = 4'h9;
   localparam logic [3:0] OP_MULHSU = 4'hA;
   localparam logic [3:0] OP_MULHU  = 4'hB;
   localparam logic [3:0] OP_DIV    = 4'hC;
   localparam logic [3:0] OP_DIVU   = 4'hD;
   localparam logic [3:0] OP_REM    = 4'hE;
   localparam logic [3:0] OP_REMU   = 4'hF;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        busy;
   logic [1:0]  dbg_state;
   int          checks;
   int          errors;

   muldiv_seq_if #(.XLEN(32)) bus ();

   muldiv_seq dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .bus         (bus),
      .busy        (busy),
      .dbg_state_o (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents a request in the current cycle; returns one cycle after the accept edge.
   task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.req_valid = 1'b1;
      bus.op        = op;
      bus.rs1       = a;
      bus.rs2       = b;
      chk("req_ready_before_accept", {63'd0, bus.req_ready}, 64'd1);
      step();
      bus.req_valid = 1'b0;
      bus.op        = 4'($urandom_range(0, 15));
      bus.rs1       = $urandom;
      bus.rs2       = $urandom;
   endtask

   // Counts cycles from T+1 until resp_valid, checking busy/req_ready while waiting.
   task automatic wait_resp(input string tag, input int exp_lat);
      int  lat;
      logic bad;
      lat = 1;
      bad = 1'b0;
      while (!bus.resp_valid && lat < 100) begin
         if (!busy || bus.req_ready) bad = 1'b1;
         step();
         lat++;
      end
      chk({tag, "_busy_while_run"}, {63'd0, bad}, 64'd0);
      chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
   endtask

   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      start_op(op, a, b);
      wait_resp(tag, exp_lat);
      chk({tag, "_result"}, {32'd0, bus.result}, {32'd0, exp_res});
      bus.resp_ready = 1'b1;
      step();
      bus.resp_ready = 1'b0;
      chk({tag, "_back_idle"}, {62'd0, bus.req_ready, bus.resp_valid}, 64'd2);
   endtask

   initial begin
      logic        seen;
      logic [31:0] held;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      flush  = 1'b0;
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b0;
      bus.op  = '0;
      bus.rs1 = '0;
      bus.rs2 = '0;
      repeat (3) step();
      chk("reset_req_ready", {63'd0, bus.req_ready}, 64'd1);
      chk("reset_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
      chk("reset_result", {32'd0, bus.result}, 64'd0);
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_state", {62'd0, dbg_state}, 64'd0);
      rst_n = 1'b1;
      step();

      run_op("mul_7_m3",      OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
      run_op("mulh_7_m3",     OP_MULH,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 33);
      run_op("mulhu_max",     OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
      run_op("mulhsu_m1_2",   OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
      run_op("mulhsu_m1_max", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
      run_op("mulh_min_min",  OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
      run_op("div_m7_2",      OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
      run_op("rem_m7_2",      OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
      run_op("divu_100_7",    OP_DIVU,   32'd100,      32'd7,        32'd14,       33);
      run_op("remu_100_7",    OP_REMU,   32'd100,      32'd7,        32'd2,        33);
      run_op("divu_big",      OP_DIVU,   32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0,        33);
      run_op("remu_big",      OP_REMU,   32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
      run_op("rem_7_m2",      OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33);
      run_op("div_5_0",       OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1);
      run_op("remu_5_0",      OP_REMU,   32'd5,        32'd0,        32'd5,        1);
      run_op("div_ovf",       OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      run_op("rem_ovf",       OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
      run_op("non_m_op",      4'h3,      32'd9,        32'd9,        32'd0,        1);

      // Flush at T+10 of a DIV: no response, then a fresh MUL works.
      start_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
      repeat (9) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_req_ready", {63'd0, bus.req_ready}, 64'd1);
      chk("flush_busy", {63'd0, busy}, 64'd0);
      seen = 1'b0;
      repeat (40) begin
         if (bus.resp_valid) seen = 1'b1;
         step();
      end
      chk("flush_no_resp", {63'd0, seen}, 64'd0);
      run_op("mul_3_4", OP_MUL, 32'd3, 32'd4, 32'd12, 33);

      // Flush together with a request in IDLE blocks the accept.
      bus.req_valid = 1'b1;
      bus.op  = OP_MUL;
      bus.rs1 = 32'd1;
      bus.rs2 = 32'd1;
      flush   = 1'b1;
      step();
      flush = 1'b0;
      bus.req_valid = 1'b0;
      chk("flush_blocks_accept", {63'd0, busy}, 64'd0);

      // Asynchronous reset in the middle of RUN.
      start_op(OP_DIVU, 32'd100, 32'd7);
      repeat (5) step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_req_ready", {63'd0, bus.req_ready}, 64'd1);
      chk("rst_mid_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
      chk("rst_mid_result", {32'd0, bus.result}, 64'd0);
      chk("rst_mid_busy", {63'd0, busy}, 64'd0);
      chk("rst_mid_state", {62'd0, dbg_state}, 64'd0);
      step();
      rst_n = 1'b1;
      step();

      // Backpressure: response holds for 5 cycles and new requests are refused.
      start_op(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_resp("bp", 33);
      held = bus.result;
      chk("bp_result", {32'd0, held}, {32'd0, 32'hFFFFFFFE});
      bus.req_valid = 1'b1;
      bus.op  = OP_MUL;
      bus.rs1 = 32'd2;
      bus.rs2 = 32'd2;
      seen = 1'b0;
      repeat (5) begin
         if (!bus.resp_valid || bus.result !== held || bus.req_ready) seen = 1'b1;
         step();
      end
      chk("bp_stable", {63'd0, seen}, 64'd0);
      chk("bp_result_after", {32'd0, bus.result}, {32'd0, 32'hFFFFFFFE});
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      step();
      bus.resp_ready = 1'b0;
      chk("bp_release_state", {62'd0, dbg_state}, 64'd0);
      chk("bp_release_ready", {63'd0, bus.req_ready}, 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the M-extension operations in the execute stage: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Accepts one operation at a time through a valid/ready handshake and runs an iterative radix-2 engine: shift-add for multiply, restoring division for divide and remainder.
- Holds the result until the pipeline takes it.
- Drives a busy flag so the hazard unit stalls IF/ID/EX while an operation is in flight.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, $clog2(XLEN)+1, width of the iteration counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush; aborts any operation in flight.
- req_valid  in  1  execute stage presents an operation.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- op  in  ALU_OP  ALU control code from all_pkgs (ALU_MUL..ALU_DIVU, ALU_REM, ALU_REMU).
- rs1  in  XLEN  operand A (multiplicand or dividend).
- rs2  in  XLEN  operand B (multiplier or divisor).
- resp_valid  out  1  result available; high only in DONE.
- resp_ready  in  1  consumer takes the result this cycle.
- result  out  XLEN  result, stable while resp_valid is high.
- busy  out  1  state != IDLE; feeds the hazard unit's stall.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, counter=0, all datapath registers=0, req_ready=1, resp_valid=0, result=0, busy=0.
- FSM states are IDLE, RUN, DONE. The accept cycle T is the cycle where req_valid && req_ready && !flush.
- IDLE on accept:
  - Latch op.
  - Latch operand magnitudes: take the absolute value only for signed operands (MULH: both operands; MULHSU: rs1 only; DIV/REM: both operands).
  - Latch the sign-correction flags: product negative = sA^sB; quotient negative = sA^sB; remainder negative = sA.
  - Fast path to DONE at T+1, with no iteration, for:
    - divisor==0: DIV/DIVU result = all ones; REM/REMU result = rs1.
    - signed overflow (DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF): DIV result = 0x80000000; REM result = 0.
    - op not one of the eight M codes: result = 0.
  - Otherwise go to RUN with counter=XLEN.
- RUN, one iteration per cycle, counter decrements:
  - Multiply: 2*XLEN-bit accumulator. If the multiplier LSB is set, add the multiplicand into the upper half, then shift right by 1.
  - Divide: shift the {remainder,quotient} pair left by 1, trial-subtract the divisor from the remainder. If non-negative, keep the difference and set quotient LSB=1.
  - When counter reaches 1, the next state is DONE. Exactly XLEN RUN cycles, T+1..T+XLEN.
- DONE, entered at T+XLEN+1:
  - resp_valid=1.
  - result selected from the registered state after sign correction (two's complement):
    - MUL: low half.
    - MULH/MULHSU/MULHU: high half, where the correction applies to the full 2*XLEN product before selecting the half.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - result is registered or derived only from registers; no combinational path from rs1/rs2.
  - Stay in DONE while resp_ready=0, with result held stable.
  - On resp_ready=1, go to IDLE; the next accept is possible no earlier than the following cycle (no back-to-back accept from DONE).
- Total latency: iterative ops give resp_valid at T+XLEN+1 (T+33 for XLEN=32); fast-path ops give resp_valid at T+1.
- flush:
  - Synchronous, highest priority.
  - In any state, next state=IDLE; resp_valid deasserts at the next edge and no response is produced.
  - flush together with req_valid in IDLE: the request is not accepted.
- Inputs op/rs1/rs2 are ignored outside the accept cycle; changing them mid-operation has no effect.
- Only signed operands get magnitude conversion; unsigned operands are used raw, including MULHSU rs2.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3) -> resp_valid at T+33, result=0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU rs1=0xFFFFFFFF (-1), rs2=2 -> 0xFFFFFFFF; busy high T+1..T+33, req_ready low throughout.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2, all at T+33.
- Special cases at T+1:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
- Flush and reset:
  - flush asserted at T+10 of a DIV -> resp_valid never rises, req_ready=1 at T+11, and a new MUL 3x4 then returns 12.
  - rst_n dropped mid-RUN -> outputs reach reset values immediately.
- Backpressure: resp_ready held low 5 cycles in DONE -> resp_valid and result stable for all 5 cycles, and req_valid is not accepted; resp_ready=1 -> IDLE the next cycle.
